// File: rtl/ofmap_wb_pkg.sv
// ofmap_writeback shared types, constants and helpers.
// OFMAP_WB_BYTE_STROBE_EN widens FIFO entries with a 4-bit byte strobe.
package ofmap_wb_pkg;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_FLUSH,
    WB_DRAIN
  } wb_state_e;

  localparam int WB_BYTES_PER_WORD = 4;
  localparam int WB_ADDR_STEP      = 4;

`ifdef OFMAP_WB_BYTE_STROBE_EN
  localparam int WB_ENTRY_W = 36;
`else
  localparam int WB_ENTRY_W = 32;
`endif

  // strobe for a partial word holding cnt valid lanes
  function automatic logic [3:0] wb_strb(input logic [1:0] cnt);
    logic [4:0] m;
    m = (5'd1 << cnt) - 5'd1;
    return m[3:0];
  endfunction

endpackage

// File: rtl/ofmap_wb_if.sv
// ofmap_writeback external memory write bus (req/ack).
// OFMAP_WB_BYTE_STROBE_EN adds dram_wstrb.
interface ofmap_wb_if #(
  parameter int ADDR_W = 16
);
  logic              dram_req;
  logic [ADDR_W-1:0] dram_addr;
  logic [31:0]       dram_wdata;
  logic              dram_ack;
`ifdef OFMAP_WB_BYTE_STROBE_EN
  logic [3:0]        dram_wstrb;
`endif

  modport master (
    output dram_req,
    output dram_addr,
    output dram_wdata,
`ifdef OFMAP_WB_BYTE_STROBE_EN
    output dram_wstrb,
`endif
    input  dram_ack
  );

  modport slave (
    input  dram_req,
    input  dram_addr,
    input  dram_wdata,
`ifdef OFMAP_WB_BYTE_STROBE_EN
    input  dram_wstrb,
`endif
    output dram_ack
  );
endinterface

// File: rtl/ofmap_writeback_fifo.sv
// wb_fifo: synchronous FIFO, push accepted while full if a pop
// happens in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: packs int8 results (or passes raw words) into a FIFO
// and writes them to memory. OFMAP_WB_BYTE_STROBE_EN adds dram_wstrb.
module ofmap_writeback
  import ofmap_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              raw_mode,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              src_done,
  ofmap_wb_if.master        bus,
  output logic              wb_done,
  output logic              overflow,
  output logic              busy
);

  wb_state_e         state_q;
  wb_state_e         state_d;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_cnt;
  logic [23:0]       pack_q;
  logic              ovf_q;

  logic              clr;
  logic              push;
  logic [31:0]       push_word;
  logic              done;
  logic              pop;
  logic [WB_ENTRY_W-1:0] push_data;
  logic [WB_ENTRY_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    push      = 1'b0;
    push_word = '0;
    done      = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (start) begin
          state_d = WB_RUN;
          clr     = 1'b1;
        end
      end
      WB_RUN: begin
        if (in_valid) begin
          if (mode_q) begin
            push      = 1'b1;
            push_word = in_data;
          end else if (byte_cnt == 2'd3) begin
            push      = 1'b1;
            push_word = {in_data[7:0], pack_q};
          end
        end
        if (src_done) state_d = WB_FLUSH;
      end
      WB_FLUSH: begin
        if (byte_cnt != 2'd0) begin
          push      = 1'b1;
          push_word = {8'h00, pack_q};
        end
        state_d = WB_DRAIN;
      end
      WB_DRAIN: begin
        if (fifo_empty) begin
          state_d = WB_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign pop = bus.dram_req && bus.dram_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 1'b0;
      addr_q   <= '0;
      byte_cnt <= '0;
      pack_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      mode_q   <= raw_mode;
      addr_q   <= {base_addr[ADDR_W-1:2], 2'b00};
      byte_cnt <= '0;
      pack_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (pop) addr_q <= addr_q + ADDR_W'(WB_ADDR_STEP);
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
      if (state_q == WB_RUN && in_valid && !mode_q) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    pack_q[7:0]   <= in_data[7:0];
          2'd1:    pack_q[15:8]  <= in_data[7:0];
          2'd2:    pack_q[23:16] <= in_data[7:0];
          default: pack_q        <= '0;
        endcase
      end
      if (state_q == WB_FLUSH) begin
        byte_cnt <= '0;
        pack_q   <= '0;
      end
    end
  end

`ifdef OFMAP_WB_BYTE_STROBE_EN
  logic [3:0] push_strb;
  assign push_strb = (state_q == WB_FLUSH) ? wb_strb(byte_cnt) : 4'hF;
  assign push_data = {push_strb, push_word};
  assign bus.dram_wstrb = fifo_empty ? 4'h0 : head[35:32];
`else
  assign push_data = push_word;
`endif

  wb_fifo #(
    .WIDTH (WB_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.dram_req   = !fifo_empty && (state_q != WB_IDLE);
  assign bus.dram_addr  = addr_q;
  assign bus.dram_wdata = fifo_empty ? 32'h0 : head[31:0];

  assign wb_done  = done && !rst;
  assign overflow = ovf_q;
  assign busy     = (state_q != WB_IDLE);

endmodule

// File: tb/tb_ofmap_writeback.sv
// ofmap_writeback bench: scoreboard of expected memory writes
// plus per-scenario checks of handshake, latency and flags.
module tb_ofmap_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic        raw_mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        src_done;
  logic        wb_done;
  logic        overflow;
  logic        busy;

  ofmap_wb_if #(.ADDR_W(16)) bus();

  ofmap_writeback #(
    .FIFO_DEPTH (4),
    .ADDR_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .raw_mode  (raw_mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .src_done  (src_done),
    .bus       (bus),
    .wb_done   (wb_done),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          ack_mode = 0;
  bit          hold_v = 0;
  logic [15:0] hold_addr;
  logic [31:0] hold_data;

  logic [15:0] model_addr;
  logic [31:0] model_word;
  int          model_lanes;
  bit          model_raw;

  // one clock: sample at negedge, then drive ack just after posedge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (wb_done) done_cnt++;
    if (hold_v) begin
      vectors++;
      if (!(bus.dram_req === 1'b1 && bus.dram_addr === hold_addr &&
            bus.dram_wdata === hold_data)) begin
        errors++;
        $display("FAIL hold_stable: req=%b addr=%h data=%h required req=1 addr=%h data=%h",
                 bus.dram_req, bus.dram_addr, bus.dram_wdata, hold_addr, hold_data);
      end
    end
    hold_v    = bus.dram_req && !bus.dram_ack && !rst;
    hold_addr = bus.dram_addr;
    hold_data = bus.dram_wdata;
    if (bus.dram_req && bus.dram_ack && !rst) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h required no write",
                 bus.dram_addr, bus.dram_wdata);
      end else begin
        e = sb.pop_front();
        if (bus.dram_addr !== e.addr || bus.dram_wdata !== e.data
`ifdef OFMAP_WB_BYTE_STROBE_EN
            || bus.dram_wstrb !== e.strb
`endif
           ) begin
          errors++;
          $display("FAIL write: addr=%h data=%h required addr=%h data=%h strb=%b",
                   bus.dram_addr, bus.dram_wdata, e.addr, e.data, e.strb);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    case (ack_mode)
      0:       bus.dram_ack = 1'b1;
      1:       bus.dram_ack = (cyc % 3 == 0);
      default: bus.dram_ack = 1'b0;
    endcase
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.addr = model_addr;
    e.data = d;
    e.strb = s;
    sb.push_back(e);
    model_addr = model_addr + 16'd4;
  endtask

  task automatic model_flush();
    if (model_lanes != 0) begin
      push_exp(model_word, 4'((1 << model_lanes) - 1));
      model_word  = '0;
      model_lanes = 0;
    end
  endtask

  task automatic do_start(input logic [15:0] base, input bit raw);
    model_addr  = base & 16'hFFFC;
    model_raw   = raw;
    model_word  = '0;
    model_lanes = 0;
    done_cnt    = 0;
    start     = 1'b1;
    base_addr = base;
    raw_mode  = raw;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit keep, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    src_done = last;
    if (model_raw) begin
      if (keep) push_exp(d, 4'hF);
    end else begin
      model_word[model_lanes*8 +: 8] = d[7:0];
      model_lanes++;
      if (model_lanes == 4) begin
        push_exp(model_word, 4'hF);
        model_word  = '0;
        model_lanes = 0;
      end
    end
    if (last) model_flush();
    step();
    in_valid = 1'b0;
    in_data  = '0;
    src_done = 1'b0;
  endtask

  task automatic end_stream();
    src_done = 1'b1;
    model_flush();
    step();
    src_done = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: no wb_done within %0d cycles", budget);
    end
    repeat (3) step();
    vectors++;
    if (done_cnt !== 1 || sb.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL completion: done_pulses=%0d pending=%0d busy=%b required 1 0 0",
               done_cnt, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (bus.dram_req !== 1'b0 || bus.dram_addr !== 16'h0 ||
        bus.dram_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: req=%b addr=%h data=%h required 0 0 0",
               bus.dram_req, bus.dram_addr, bus.dram_wdata);
    end
    vectors++;
    if (wb_done !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: done=%b ovf=%b busy=%b required 0 0 0",
               wb_done, overflow, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_packed();
    int n;
    ack_mode = 0;
    do_start(16'h0100, 1'b0);
    beat(32'h11, 1, 0);
    beat(32'h22, 1, 0);
    beat(32'h33, 1, 0);
    beat(32'h44, 1, 0);
    vectors++;
    if (bus.dram_req !== 1'b1 || bus.dram_wdata !== 32'h44332211 ||
        bus.dram_addr !== 16'h0100) begin
      errors++;
      $display("FAIL push_latency: req=%b data=%h addr=%h required 1 44332211 0100",
               bus.dram_req, bus.dram_wdata, bus.dram_addr);
    end
    beat(32'h55, 1, 0);
    beat(32'h66, 1, 0);
    beat(32'h77, 1, 0);
    beat(32'h88, 1, 0);
    end_stream();
    wait_done(20, n);
  endtask

  task automatic test_partial();
    int n;
    ack_mode = 0;
    do_start(16'h0202, 1'b0);
    for (int i = 1; i <= 5; i++) beat(32'(i), 1, 0);
    end_stream();
    wait_done(20, n);
  endtask

  task automatic test_raw_slow();
    int n;
    ack_mode = 1;
    do_start(16'h0300, 1'b1);
    beat(32'hDEADBEEF, 1, 0);
    beat(32'h1, 1, 0);
    beat(32'h2, 1, 0);
    end_stream();
    wait_done(40, n);
  endtask

  task automatic test_overflow();
    int n;
    ack_mode = 2;
    do_start(16'h0400, 1'b1);
    for (int i = 0; i < 4; i++) beat(32'hA000 + 32'(i), 1, 0);
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full: got %b required 0", overflow);
    end
    beat(32'hA004, 0, 0);
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_drop: got %b required 1", overflow);
    end
    beat(32'hA005, 0, 0);
    end_stream();
    ack_mode = 0;
    wait_done(20, n);
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_done_with_last();
    int n;
    ack_mode = 0;
    do_start(16'h0500, 1'b0);
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared_by_start: got %b required 0", overflow);
    end
    beat(32'hC1, 1, 0);
    beat(32'hC2, 1, 0);
    beat(32'hC3, 1, 0);
    beat(32'hC4, 1, 1);
    wait_done(20, n);
    vectors++;
    if (n !== 2) begin
      errors++;
      $display("FAIL drain_latency: done after %0d cycles required 2", n);
    end
  endtask

  task automatic test_reset_drain();
    int n;
    ack_mode = 2;
    do_start(16'h0600, 1'b1);
    beat(32'h600D0001, 1, 0);
    beat(32'h600D0002, 1, 0);
    end_stream();
    step();
    vectors++;
    if (busy !== 1'b1 || bus.dram_req !== 1'b1) begin
      errors++;
      $display("FAIL drain_pending: busy=%b req=%b required 1 1", busy, bus.dram_req);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    vectors++;
    if (bus.dram_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drain: req=%b busy=%b required 0 0",
               bus.dram_req, busy);
    end
    step();
    step();
    vectors++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL no_done_after_rst: pulses=%0d required 0", done_cnt);
    end
    ack_mode = 0;
    do_start(16'h0700, 1'b0);
    beat(32'hA1, 1, 0);
    beat(32'hA2, 1, 0);
    beat(32'hA3, 1, 0);
    beat(32'hA4, 1, 0);
    end_stream();
    wait_done(20, n);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    raw_mode     = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    src_done     = 1'b0;
    bus.dram_ack = 1'b0;
    ack_mode     = 2;
    test_reset();
    test_packed();
    test_partial();
    test_raw_slow();
    test_overflow();
    test_done_with_last();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ofmap_writeback.md
# ofmap_writeback

Downstream write-back stage for the int8 accelerator output stream. It captures the post-processed feature-map values the accelerator emits on its `valid`/`ofmap` pair. In packed mode it gathers four int8 results into one 32-bit little-endian word; in raw mode it forwards 32-bit words unchanged. Words are held in a small FIFO and written to external memory through a req/ack handshake at consecutive word addresses, and `wb_done` pulses once the last word has been written.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of 32-bit entries in the FIFO; must be a power of two, at least 2.
- `ADDR_W`, default 16: width of the byte address.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse; latches `base_addr` and `raw_mode`.
- `base_addr`  in  `ADDR_W`: byte address of the first word; bits [1:0] are ignored.
- `raw_mode`  in  1: 0 = pack `in_data[7:0]` four per word; 1 = pass `in_data[31:0]` through, one word per beat.
- `in_valid`  in  1: input beat valid. There is no backpressure; a beat offered with `in_valid` high is always consumed.
- `in_data`  in  32: input value.
- `src_done`  in  1: pulse from the upstream controller meaning no further beats will arrive.
- `dram_req`  out  1: write request.
- `dram_addr`  out  `ADDR_W`: write byte address.
- `dram_wdata`  out  32: write data.
- `dram_ack`  in  1: write accepted; sampled while `dram_req` is high.
- `wb_done`  out  1: one-cycle completion pulse.
- `overflow`  out  1: sticky flag; set when a word is lost.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN.
  - IDLE → RUN on `start`. On that transition: latch the mode, set the address pointer to `{base_addr[ADDR_W-1:2], 2'b00}`, clear the byte counter, the FIFO and `overflow`.
  - `start` is ignored in every state other than IDLE.
- RUN, packed mode:
  - Each `in_valid` writes `in_data[7:0]` into lane `byte_cnt` (lane 0 = bits [7:0]), then `byte_cnt` increments mod 4.
  - When lane 3 is written, the assembled word is pushed to the FIFO.
- RUN, raw mode: each `in_valid` pushes `in_data` directly.
- RUN → FLUSH on `src_done`.
  - If `in_valid` is high in the same cycle, that beat is accepted first.
  - FLUSH lasts one cycle. If `byte_cnt` ≠ 0, the partial word is pushed with unused lanes zero. Then → DRAIN.
- DRAIN → IDLE when the FIFO is empty and no request is outstanding. `wb_done` is high on that transition cycle.
- Write port (active in RUN, FLUSH and DRAIN):
  - `dram_req` = FIFO not empty; `dram_wdata` = FIFO head.
  - `dram_addr`, `dram_wdata` and `dram_req` stay stable until `dram_ack`.
  - On `dram_ack`: pop the FIFO and add 4 to the pointer. The pointer wraps mod 2^`ADDR_W`.
- Push while full:
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise the word is dropped and `overflow` is set; it stays set until the next `start` or `rst`.
- `in_valid` is ignored in IDLE and DRAIN.
- `rst` at any time: return to IDLE, empty the FIFO, clear the counters.

## Timing
- Reset values: `dram_req`=0, `dram_addr`=0, `dram_wdata`=0, `wb_done`=0, `overflow`=0, `busy`=0.
- Push latency: if a word completes in cycle t, the FIFO write occurs at the end of t and `dram_req` is high in t+1 when the FIFO was previously empty.
- Back-to-back writes: with `dram_ack` held high, one word is written per cycle.
- Drain latency: `wb_done` asserts in the cycle after the ack of the last word. With no pending data, it asserts the cycle after FLUSH.
- `busy` is registered from the state.

## Configuration
- Macro `OFMAP_WB_BYTE_STROBE_EN`.
- Defined:
  - Adds output `dram_wstrb` [3:0], stored alongside each FIFO entry.
  - Full words carry 4'b1111; a flushed partial word carries one strobe bit per valid lane (e.g. 2 bytes → 4'b0011); raw mode always carries 4'b1111.
- Undefined: no strobe port; partial words are zero-padded and written as whole words.

## Structure
- Shared package `ofmap_wb_pkg`:
  - state enum `wb_state_e`.
  - constants `WB_BYTES_PER_WORD = 4` and `WB_ADDR_STEP = 4`.
- Sub-module `wb_fifo`: synchronous FIFO with parameters `WIDTH` and `DEPTH`. It provides full/empty outputs and allows simultaneous push and pop while full.

## Test plan
- Packed mode, `base_addr`=0x100, bytes 0x11,0x22,…,0x88, then `src_done`, `dram_ack` always 1 → two writes: 0x44332211 @0x100 and 0x88776655 @0x104; `wb_done` pulses once.
- Packed mode, 5 bytes 0x01..0x05, then `src_done` → second write is 0x00000005 @+4; with the macro defined, `dram_wstrb`=4'b0001.
- Raw mode, three words 0xDEADBEEF, 0x1, 0x2, with `dram_ack` high only every 3rd cycle → all three written in order at +0, +4, +8; `dram_req`, `dram_addr` and `dram_wdata` stay stable while waiting.
- `FIFO_DEPTH`=4, raw mode, `dram_ack`=0 for 6 beats → `overflow`=1 after the 5th beat; words 0–3 are written once `dram_ack` rises.
- `src_done` in the same cycle as the 4th `in_valid` → that word is written and no extra partial word is written.
- `rst` asserted mid-DRAIN with 2 entries queued → next cycle `dram_req`=0, `busy`=0, no `wb_done`; a new `start` then runs cleanly.
